// File: rtl/board_tx_if.sv
// Board read port plus outgoing byte stream. The master side is the serializer;
// the slave side is the board read port and the UART transmitter.
interface board_tx_if;
  logic [5:0] cell_xy;
  logic [1:0] cell_code;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output cell_xy, tx_data, tx_valid, input cell_code, tx_ready);
  modport slave  (input cell_xy, tx_data, tx_valid, output cell_code, tx_ready);
endinterface

// File: rtl/board_tx.sv
// Streams an 8x8 board as a 19-byte frame (header, 16 payload, count, checksum), 116 cycles
// per frame at READ_LAT=2 with tx_ready high; tx_data/tx_valid hold while tx_ready is low.
module board_tx #(
  parameter logic [7:0] HEADER   = 8'hA5,
  parameter int         READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_req,
  board_tx_if.master        bus,
  output logic              busy,
  output logic              frame_done,
  output logic [6:0]        intact_cnt,
  output logic              fleet_sunk
);

  typedef enum logic [2:0] {IDLE, HDR, SCAN, PAY, CNT, CHK, DONE} state_t;

  // Scan-cycle counter: captures land READ_LAT edges after each address update.
  localparam logic [3:0] CAP_FIRST = 4'(READ_LAT - 1);
  localparam logic [3:0] CAP_LAST  = 4'(READ_LAT + 2);
  localparam logic [3:0] SCAN_END  = 4'(READ_LAT + 3);

  state_t     state, state_nxt;
  logic [3:0] sc;
  logic [7:0] pay;
  logic [7:0] chk;
  logic [6:0] acc;
  logic [1:0] lane;
  logic       accept;
  logic       last_byte;

  assign accept    = bus.tx_valid && bus.tx_ready;
  assign lane      = 2'(sc - CAP_FIRST);
  assign last_byte = (bus.cell_xy[5:2] == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (send_req) state_nxt = HDR;
      HDR:     if (accept) state_nxt = SCAN;
      SCAN:    if (sc == SCAN_END) state_nxt = PAY;
      PAY:     if (accept) state_nxt = last_byte ? CNT : SCAN;
      CNT:     if (accept) state_nxt = CHK;
      CHK:     if (accept) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.tx_valid = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    case (state)
      IDLE:                busy = 1'b0;
      HDR, PAY, CNT, CHK:  bus.tx_valid = 1'b1;
      DONE:                frame_done = 1'b1;
      default:             ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cell_xy <= '0;
      bus.tx_data <= '0;
      sc          <= '0;
      pay         <= '0;
      chk         <= '0;
      acc         <= '0;
      intact_cnt  <= '0;
      fleet_sunk  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (send_req) begin
            bus.cell_xy <= '0;
            bus.tx_data <= HEADER;
            acc         <= '0;
            chk         <= '0;
          end
        end
        HDR: sc <= '0;
        SCAN: begin
          sc <= sc + 4'd1;
          if (sc < 4'd3) bus.cell_xy <= bus.cell_xy + 6'd1;
          if (sc >= CAP_FIRST && sc <= CAP_LAST) begin
            pay[{lane, 1'b0} +: 2] <= bus.cell_code;
            if (bus.cell_code == 2'b01) acc <= acc + 7'd1;
          end
          if (sc == SCAN_END) bus.tx_data <= pay;
        end
        PAY: begin
          sc <= '0;
          if (accept) begin
            chk <= chk ^ bus.tx_data;
            // Address stays on cell 63 after the last byte; otherwise step to the next group.
            if (last_byte) bus.tx_data <= {1'b0, acc};
            else           bus.cell_xy <= bus.cell_xy + 6'd1;
          end
        end
        CNT: begin
          if (accept) begin
            chk         <= chk ^ bus.tx_data;
            bus.tx_data <= chk ^ bus.tx_data;
          end
        end
        CHK: begin
          if (accept) begin
            intact_cnt <= acc;
            fleet_sunk <= (acc == 7'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_tx.sv
// Bench for board_tx: registered board model, expected-frame scoreboard, throttled sink.
module tb_board_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       send_req;
  logic       busy;
  logic       frame_done;
  logic [6:0] intact_cnt;
  logic       fleet_sunk;

  board_tx_if bus();

  board_tx #(.HEADER(8'hA5), .READ_LAT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .send_req   (send_req),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .intact_cnt (intact_cnt),
    .fleet_sunk (fleet_sunk)
  );

  always #5 clk = ~clk;

  logic [1:0] board [64];
  logic [1:0] rd_q;
  always @(posedge clk) rd_q <= board[bus.cell_xy];
  assign bus.cell_code = rd_q;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_base;
  int         n_checks;
  int         n_fail;
  int         hold_viol;
  int         stall_left;
  bit         rand_ready;
  logic [6:0] exp_intact;

  logic       stalled_prev;
  logic [7:0] data_prev;

  always @(negedge clk) begin
    if (rst) begin
      stalled_prev <= 1'b0;
    end else begin
      if (stalled_prev && (bus.tx_valid !== 1'b1 || bus.tx_data !== data_prev))
        hold_viol <= hold_viol + 1;
      if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
      stalled_prev <= bus.tx_valid && !bus.tx_ready;
      data_prev    <= bus.tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_left > 0 && bus.tx_valid && (rx_q.size() - rx_base) == 6) begin
      bus.tx_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      bus.tx_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.tx_ready = 1'b1;
    end
  endtask

  function automatic void push_frame();
    logic [7:0] b;
    logic [7:0] c;
    logic [6:0] cnt;
    c   = '0;
    cnt = '0;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 16; k++) begin
      b = '0;
      for (int l = 0; l < 4; l++) begin
        b[2*l +: 2] = board[4*k + l];
        if (board[4*k + l] == 2'b01) cnt++;
      end
      exp_q.push_back(b);
      c ^= b;
    end
    exp_q.push_back({1'b0, cnt});
    c ^= {1'b0, cnt};
    exp_q.push_back(c);
    exp_intact = cnt;
  endfunction

  task automatic start_frame();
    push_frame();
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (frame_done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks += 7;
    if (bus.cell_xy !== 6'd0)  begin n_fail++; $display("FAIL reset_cell_xy got %h want 00", bus.cell_xy); end
    if (bus.tx_data !== 8'd0)  begin n_fail++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (frame_done !== 1'b0)   begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    if (intact_cnt !== 7'd0)   begin n_fail++; $display("FAIL reset_intact got %0d want 0", intact_cnt); end
    if (fleet_sunk !== 1'b0)   begin n_fail++; $display("FAIL reset_sunk got %b want 0", fleet_sunk); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_board();
    int cyc;
    logic [7:0] e;
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
    start_frame();
    n_checks += 3;
    if (busy !== 1'b1)          begin n_fail++; $display("FAIL start_busy got %b want 1", busy); end
    if (bus.tx_valid !== 1'b1)  begin n_fail++; $display("FAIL start_valid got %b want 1", bus.tx_valid); end
    if (bus.tx_data !== 8'hA5)  begin n_fail++; $display("FAIL start_header got %h want a5", bus.tx_data); end
    wait_done(cyc);
    n_checks += 3;
    if (cyc !== 116)           begin n_fail++; $display("FAIL zero_latency got %0d want 116", cyc); end
    if (fleet_sunk !== 1'b1)   begin n_fail++; $display("FAIL zero_sunk got %b want 1", fleet_sunk); end
    if (intact_cnt !== 7'd0)   begin n_fail++; $display("FAIL zero_intact got %0d want 0", intact_cnt); end
    tick();
    n_checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_pulse frame_done %b busy %b want 0 0", frame_done, busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rx_base >= rx_q.size()) begin n_fail++; $display("FAIL zero_byte missing want %h", e); end
      else begin
        if (rx_q[rx_base] !== e) begin n_fail++; $display("FAIL zero_byte %0d got %h want %h", rx_base, rx_q[rx_base], e); end
        rx_base++;
      end
    end
  endtask

  task automatic test_patterns();
    int cyc;
    logic [7:0] e;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 64; i++) board[i] = (p == 0) ? 2'b00 : (p == 1) ? 2'b11 : 2'b01;
      if (p == 0) board[9] = 2'b01;
      start_frame();
      wait_done(cyc);
      n_checks += 3;
      if (cyc >= 3000)                   begin n_fail++; $display("FAIL pat%0d_timeout no frame_done", p); end
      if (intact_cnt !== exp_intact)     begin n_fail++; $display("FAIL pat%0d_intact got %0d want %0d", p, intact_cnt, exp_intact); end
      if (fleet_sunk !== (exp_intact == 7'd0)) begin n_fail++; $display("FAIL pat%0d_sunk got %b", p, fleet_sunk); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rx_base >= rx_q.size()) begin n_fail++; $display("FAIL pat%0d_byte missing want %h", p, e); end
        else begin
          if (rx_q[rx_base] !== e) begin n_fail++; $display("FAIL pat%0d_byte %0d got %h want %h", p, rx_base, rx_q[rx_base], e); end
          rx_base++;
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int cyc;
    int hv0;
    logic [7:0] e;
    for (int i = 0; i < 64; i++) board[i] = 2'($urandom_range(0, 3));
    hv0        = hold_viol;
    rand_ready = 1'b1;
    stall_left = 10;
    start_frame();
    wait_done(cyc);
    rand_ready = 1'b0;
    tick();
    n_checks += 4;
    if (cyc >= 3000)             begin n_fail++; $display("FAIL stall_timeout no frame_done"); end
    if (stall_left !== 0)        begin n_fail++; $display("FAIL stall_window left %0d want 0", stall_left); end
    if (hold_viol !== hv0)       begin n_fail++; $display("FAIL stall_hold violations %0d want 0", hold_viol - hv0); end
    if (rx_q.size() - rx_base !== 19) begin n_fail++; $display("FAIL stall_count got %0d want 19", rx_q.size() - rx_base); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rx_base >= rx_q.size()) begin n_fail++; $display("FAIL stall_byte missing want %h", e); end
      else begin
        if (rx_q[rx_base] !== e) begin n_fail++; $display("FAIL stall_byte %0d got %h want %h", rx_base, rx_q[rx_base], e); end
        rx_base++;
      end
    end
    stall_left = 0;
  endtask

  task automatic test_ignore_req();
    int cyc;
    int n;
    logic [7:0] e;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) board[i] = 2'($urandom_range(0, 3));
      start_frame();
      if (f == 0) begin
        n = 0;
        while (!((rx_q.size() - rx_base) == 4 && bus.tx_valid === 1'b0) && n < 500) begin tick(); n++; end
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
      end
      wait_done(cyc);
      repeat (150) tick();
      n_checks += 3;
      if (cyc >= 3000)     begin n_fail++; $display("FAIL ignore%0d_timeout no frame_done", f); end
      if (busy !== 1'b0)   begin n_fail++; $display("FAIL ignore%0d_busy got %b want 0", f, busy); end
      if (rx_q.size() - rx_base !== 19) begin n_fail++; $display("FAIL ignore%0d_count got %0d want 19", f, rx_q.size() - rx_base); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rx_base >= rx_q.size()) begin n_fail++; $display("FAIL ignore%0d_byte missing want %h", f, e); end
        else begin
          if (rx_q[rx_base] !== e) begin n_fail++; $display("FAIL ignore%0d_byte %0d got %h want %h", f, rx_base, rx_q[rx_base], e); end
          rx_base++;
        end
      end
      rx_base = rx_q.size();
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    int n;
    logic [7:0] e;
    for (int i = 0; i < 64; i++) board[i] = 2'($urandom_range(0, 3));
    start_frame();
    n = 0;
    while (!((rx_q.size() - rx_base) == 9 && bus.tx_valid === 1'b1) && n < 500) begin tick(); n++; end
    rst = 1'b1;
    tick();
    n_checks += 6;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", bus.tx_valid); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (bus.cell_xy !== 6'd0)  begin n_fail++; $display("FAIL mid_rst_cell_xy got %h want 00", bus.cell_xy); end
    if (bus.tx_data !== 8'd0)  begin n_fail++; $display("FAIL mid_rst_tx_data got %h want 00", bus.tx_data); end
    if (intact_cnt !== 7'd0)   begin n_fail++; $display("FAIL mid_rst_intact got %0d want 0", intact_cnt); end
    if (fleet_sunk !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_flags sunk %b done %b want 0 0", fleet_sunk, frame_done);
    end
    rst = 1'b0;
    exp_q.delete();
    tick();
    rx_base = rx_q.size();
    start_frame();
    wait_done(cyc);
    tick();
    n_checks += 2;
    if (cyc !== 116)           begin n_fail++; $display("FAIL mid_rst_latency got %0d want 116", cyc); end
    if (intact_cnt !== exp_intact) begin n_fail++; $display("FAIL mid_rst_intact2 got %0d want %0d", intact_cnt, exp_intact); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rx_base >= rx_q.size()) begin n_fail++; $display("FAIL mid_rst_byte missing want %h", e); end
      else begin
        if (rx_q[rx_base] !== e) begin n_fail++; $display("FAIL mid_rst_byte %0d got %h want %h", rx_base, rx_q[rx_base], e); end
        rx_base++;
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    send_req     = 1'b0;
    bus.tx_ready = 1'b1;
    rx_base      = 0;
    n_checks     = 0;
    n_fail       = 0;
    hold_viol    = 0;
    stall_left   = 0;
    rand_ready   = 1'b0;
    exp_intact   = '0;
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
    test_reset();
    test_zero_board();
    test_patterns();
    test_stall();
    test_ignore_req();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/board_tx.md
# board_tx

Frame serializer that reads a player's 8x8 ship board through its registered read port and streams it as a byte frame over a valid/ready byte interface toward the UART link to the opposing board. Sits between game_board's read port and the UART transmitter. Also reports how many intact ship cells remain, and flags a sunk fleet at the end of each frame. Write-side logic (placement, shots) stays in the board; this block only reads.

## Interface
Parameters:
- HEADER, 8'hA5, first byte of every frame
- READ_LAT, 2, clock edges from this block updating cell_xy to the edge where matching cell_code is captured

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- send_req  in  1  start a frame; sampled only in IDLE
- cell_xy  out  6  board read address, {row[2:0], col[2:0]}, registered
- cell_code  in  2  board cell code for the address, READ_LAT edges later (00 empty, 01 ship, 10 hit, 11 miss)
- tx_data  out  8  byte to transmit, registered
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts byte
- busy  out  1  high from frame start until frame_done
- frame_done  out  1  one-cycle pulse after the checksum byte is accepted
- intact_cnt  out  7  count of code-01 cells in the last completed frame
- fleet_sunk  out  1  intact_cnt == 0, updated with frame_done

## Operation
- Frame: HEADER, 16 payload bytes, count byte {1'b0, intact[6:0]}, checksum byte; 19 bytes total.
- Cell n = cell_xy value (row*8+col), 0..63. Payload byte k holds cells 4k..4k+3; cell n occupies bits [2*(n%4)+1 : 2*(n%4)].
- Checksum = XOR of the 16 payload bytes and the count byte; HEADER excluded.
- States: IDLE -> HDR -> SCAN -> PAY -> (SCAN while k<15, else CNT) -> CHK -> DONE -> IDLE.
- IDLE: busy=0, tx_valid=0. send_req=1 at an edge -> HDR; clear the intact accumulator, the checksum, and k.
- HDR: tx_valid=1, tx_data=HEADER; on accept -> SCAN.
- SCAN: issue cell addresses 4k..4k+3 on consecutive cycles. Capture each cell_code READ_LAT edges later into its lane. Add 1 to the accumulator per code 01. After the 4th capture -> PAY. tx_valid=0 throughout SCAN.
- PAY: tx_valid=1 with the packed byte. On accept, XOR the byte into the checksum, k++, then go to SCAN, or to CNT after k=15.
- CNT: send the count byte and XOR it into the checksum; on accept -> CHK.
- CHK: send the checksum; on accept -> DONE.
- DONE: pulse frame_done for one cycle; load intact_cnt and fleet_sunk from the accumulator; -> IDLE.
- Handshake: a byte transfers at an edge with tx_valid && tx_ready. While tx_valid=1 and tx_ready=0, tx_data is held stable. tx_valid never drops before acceptance.
- send_req while busy is ignored; it is not queued.
- Board contents may change mid-frame; each cell reports its value at the time it was read. No snapshot is taken.
- Reset, including mid-frame: return to IDLE. cell_xy=0, tx_data=0, tx_valid=0, busy=0, frame_done=0, intact_cnt=0, fleet_sunk=0. Any partial frame is abandoned and there is no resume.

## Timing
- send_req high at edge E0: at E0 busy=1, tx_valid=1, tx_data=HEADER.
- SCAN per byte: 4 address cycles plus READ_LAT, giving 6 cycles at default. Payload tx_valid rises on the edge after the last capture.
- With tx_ready tied high, a frame takes 1 + 16*(6+1) + 1 + 1 + 1 = 116 cycles from E0 to the frame_done pulse.
- intact_cnt and fleet_sunk change only on the DONE edge and hold between frames.
- Accumulator maximum is 64, which fits in 7 bits; no saturation is needed.

## Test plan
- All-zero board, tx_ready=1, send_req pulse -> A5, sixteen 00, count 00, checksum 00. fleet_sunk=1 and frame_done pulses 116 cycles after send_req.
- Only cell 9 = 01 -> payload byte 2 = 0x04, other payload bytes 00, count 01, checksum 05. intact_cnt=1, fleet_sunk=0.
- Board all 11 -> payload all FF, count 00, checksum 00. Board all 01 -> payload all 55, count 0x40, checksum 0x40.
- tx_ready low for 10 cycles during payload byte 5 and random throttling elsewhere -> tx_data stable while stalled. The 19 received bytes match the no-stall frame and none is duplicated.
- send_req pulsed during SCAN of byte 3 -> ignored; exactly one frame is sent. A second send_req after frame_done sends a new frame.
- rst asserted during payload byte 8 -> next cycle tx_valid=0, busy=0, all outputs at reset values. A following send_req produces a full, correct 19-byte frame.
